wired_cdb_arbiter: RTL and testbench

- Merges completion results from all functional-unit result FIFOs onto the two CDB lanes that feed the ROB and the IQ snoop ports. Sources are ALU0, ALU1, LSU, MDU and FPU.
- Lane b writes only ROB bank b, where the bank is wid[0]. This removes ROB bank conflicts by construction.
- Arbitration per lane is fixed priority, ALU0 > ALU1 > LSU > MDU > FPU. A per-source anti-starvation counter stops the FPU/MDU FIFOs from being locked out.
- Output is registered: one cycle from grant to CDB.

---
 rtl/wired_cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_wired_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wired_cdb_arbiter
// Brief    : Merges functional-unit result FIFOs onto two CDB lanes.
//            Lane b carries only results whose wid[0]==b.
//            Each lane uses fixed priority, and a starvation promotion
//            keeps low-priority sources from being locked out.
// Revision : 1.0 - initial release
// ============================================================================

package wired_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [6:0]  wid;
        logic [31:0] wdata;
        logic        excp_en;
        logic [5:0]  excp;
        logic [4:0]  fp_excp;
        logic [7:0]  fcc;
        logic        jump_en;
        logic [31:0] jump_target;
    } pipeline_cdb_t;
endpackage

module wired_cdb_arbiter
    import wired_cdb_pkg::*;
#(
    parameter int SRC_CNT      = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  pipeline_cdb_t [SRC_CNT-1:0]  src_cdb_i,
    output logic [SRC_CNT-1:0]           src_ready_o,
    output pipeline_cdb_t [1:0]          cdb_o,
    input  logic                         flush_i,
    output logic                         starve_evt_o
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_IDX_W = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0]            r_wait_cnt [SRC_CNT];
    pipeline_cdb_t [1:0]           r_cdb;
    logic                          r_starve_evt;

    logic [SRC_CNT-1:0]            w_urgent;
    logic [1:0][SRC_CNT-1:0]       w_cand;
    logic [1:0][SRC_CNT-1:0]       w_pool;
    logic [1:0][c_IDX_W-1:0]       w_lane_idx;
    logic [1:0]                    w_lane_hit;
    logic [SRC_CNT-1:0]            w_grant;

    // Per-source lane steering and urgency flags
    generate
        for (genvar s = 0; s < SRC_CNT; s++) begin : g_src
            assign w_urgent[s]  = (r_wait_cnt[s] == c_LIMIT);
            assign w_cand[0][s] = src_cdb_i[s].valid & ~src_cdb_i[s].wid[0];
            assign w_cand[1][s] = src_cdb_i[s].valid &  src_cdb_i[s].wid[0];
        end
    endgenerate

    // Per-lane winner: urgent candidates preempt, then lowest index wins
    always_comb begin
        w_pool     = '0;
        w_lane_idx = '0;
        w_lane_hit = '0;
        w_grant    = '0;
        for (int b = 0; b < 2; b++) begin
            w_pool[b] = (|(w_cand[b] & w_urgent)) ? (w_cand[b] & w_urgent) : w_cand[b];
            for (int s = SRC_CNT - 1; s >= 0; s--) begin
                if (w_pool[b][s]) begin
                    w_lane_idx[b] = c_IDX_W'(s);
                end
            end
            w_lane_hit[b] = |w_pool[b];
            if (w_lane_hit[b]) begin
                w_grant[w_lane_idx[b]] = 1'b1;
            end
        end
    end

    // Accept is withheld during reset and flush so no FIFO pops a dropped result
    assign src_ready_o  = w_grant & {SRC_CNT{rst_n & ~flush_i}};
    assign cdb_o        = r_cdb;
    assign starve_evt_o = r_starve_evt;

    // CDB output register; payload only moves on a grant, valid qualifies it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdb        <= '0;
            r_starve_evt <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (flush_i) begin
                    r_cdb[b].valid <= 1'b0;
                end else if (w_lane_hit[b]) begin
                    r_cdb[b]       <= src_cdb_i[w_lane_idx[b]];
                    r_cdb[b].valid <= 1'b1;
                end else begin
                    r_cdb[b].valid <= 1'b0;
                end
            end
            r_starve_evt <= ~flush_i & (|(w_grant & w_urgent));
        end
    end

    // Wait counters: count consecutive lost cycles, saturating at the limit
    always_ff @(posedge clk) begin
        for (int s = 0; s < SRC_CNT; s++) begin
            if (!rst_n || flush_i || w_grant[s] || !src_cdb_i[s].valid) begin
                r_wait_cnt[s] <= '0;
            end else if (!w_urgent[s]) begin
                r_wait_cnt[s] <= r_wait_cnt[s] + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wired_cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wired_cdb_arbiter
// Brief    : Randomized scoreboard bench for wired_cdb_arbiter.
//            A driver issues stimulus and queues the expected responses.
//            A monitor compares them against the registered CDB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wired_cdb_arbiter;
    import wired_cdb_pkg::*;

    localparam int N   = 5;
    localparam int LIM = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    pipeline_cdb_t [N-1:0] src = '0;
    logic [N-1:0]          rdy;
    pipeline_cdb_t [1:0]   cdb;
    logic                  sevt;

    always #5 clk = ~clk;

    wired_cdb_arbiter #(.SRC_CNT(N), .STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_cdb_i    (src),
        .src_ready_o  (rdy),
        .cdb_o        (cdb),
        .flush_i      (flush),
        .starve_evt_o (sevt)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] v;
        logic       starve;
        logic       zero;
    } cyc_t;

    cyc_t          cyc_q[$];
    pipeline_cdb_t lane_q0[$];
    pipeline_cdb_t lane_q1[$];

    // Source and reference state
    logic          sv[N];
    pipeline_cdb_t sp[N];
    int            wc[N];
    logic [N-1:0]  last_acc = '0;
    logic          last_clr = 1'b1;
    int            gen_pct[N];
    int            gen_bank = -1;
    logic          inj[N];
    pipeline_cdb_t inj_p[N];
    logic          started = 1'b0;

    function automatic pipeline_cdb_t rand_payload(input int bank);
        pipeline_cdb_t p;
        p.valid       = 1'b1;
        p.wid         = 7'($urandom);
        if (bank >= 0) p.wid[0] = (bank == 1);
        p.wdata       = $urandom;
        p.excp_en     = 1'($urandom);
        p.excp        = 6'($urandom);
        p.fp_excp     = 5'($urandom);
        p.fcc         = 8'($urandom);
        p.jump_en     = 1'($urandom);
        p.jump_target = $urandom;
        return p;
    endfunction

    task automatic step(input logic do_flush, input logic do_rst);
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_rdy;
        logic         any_urg;
        logic [1:0]   hit;
        int           w;
        cyc_t         c;
        @(negedge clk);
        for (int s = 0; s < N; s++)
            if (last_clr || last_acc[s]) sv[s] = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (!sv[s]) begin
                if (inj[s]) begin
                    sv[s] = 1'b1; sp[s] = inj_p[s]; inj[s] = 1'b0;
                end else if ($urandom_range(99) < gen_pct[s]) begin
                    sv[s] = 1'b1; sp[s] = rand_payload(gen_bank);
                end
            end
        end
        for (int s = 0; s < N; s++) src[s] = sv[s] ? sp[s] : '0;
        flush   = do_flush;
        rst_n   = ~do_rst;
        started = 1'b1;
        #1;
        exp_g   = '0;
        any_urg = 1'b0;
        hit     = '0;
        for (int b = 0; b < 2; b++) begin
            w = -1;
            for (int s = 0; s < N; s++)
                if (w < 0 && sv[s] && (sp[s].wid[0] == (b == 1)) && wc[s] == LIM) w = s;
            if (w < 0)
                for (int s = 0; s < N; s++)
                    if (w < 0 && sv[s] && (sp[s].wid[0] == (b == 1))) w = s;
            if (w >= 0) begin
                exp_g[w] = 1'b1;
                hit[b]   = 1'b1;
                if (wc[w] == LIM) any_urg = 1'b1;
                if (!do_flush && !do_rst) begin
                    if (b == 0) lane_q0.push_back(sp[w]);
                    else        lane_q1.push_back(sp[w]);
                end
            end
        end
        exp_rdy = (do_flush || do_rst) ? '0 : exp_g;
        checks++;
        if (rdy !== exp_rdy) begin
            errors++;
            $display("FAIL src_ready t=%0t got=%b exp=%b", $time, rdy, exp_rdy);
        end
        c.v      = (do_flush || do_rst) ? 2'b00 : hit;
        c.starve = any_urg & ~do_flush & ~do_rst;
        c.zero   = do_rst;
        cyc_q.push_back(c);
        last_acc = exp_rdy;
        last_clr = do_flush | do_rst;
        for (int s = 0; s < N; s++) begin
            if (do_flush || do_rst || !sv[s] || exp_g[s]) wc[s] = 0;
            else if (wc[s] < LIM) wc[s] = wc[s] + 1;
        end
    endtask

    // Monitor: pops per-cycle expectations and lane payloads as the CDB presents them
    initial begin : monitor
        cyc_t          c;
        pipeline_cdb_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (cyc_q.size() == 0) begin
                errors++;
                $display("FAIL cyc_queue_empty t=%0t", $time);
            end else begin
                c = cyc_q.pop_front();
                if ({cdb[1].valid, cdb[0].valid} !== c.v || sevt !== c.starve) begin
                    errors++;
                    $display("FAIL cdb_valid_starve t=%0t got=%b/%b exp=%b/%b",
                             $time, {cdb[1].valid, cdb[0].valid}, sevt, c.v, c.starve);
                end
                if (c.zero) begin
                    checks++;
                    if (cdb !== '0) begin
                        errors++;
                        $display("FAIL reset_zero t=%0t got=%h exp=0", $time, cdb);
                    end
                end
            end
            if (cdb[0].valid === 1'b1) begin
                checks++;
                if (lane_q0.size() == 0) begin
                    errors++;
                    $display("FAIL lane0_unexpected t=%0t got=%h", $time, cdb[0]);
                end else begin
                    e = lane_q0.pop_front();
                    if (cdb[0] !== e) begin
                        errors++;
                        $display("FAIL lane0_payload t=%0t got=%h exp=%h", $time, cdb[0], e);
                    end
                end
            end
            if (cdb[1].valid === 1'b1) begin
                checks++;
                if (lane_q1.size() == 0) begin
                    errors++;
                    $display("FAIL lane1_unexpected t=%0t got=%h", $time, cdb[1]);
                end else begin
                    e = lane_q1.pop_front();
                    if (cdb[1] !== e) begin
                        errors++;
                        $display("FAIL lane1_payload t=%0t got=%h exp=%h", $time, cdb[1], e);
                    end
                end
            end
        end
    end

    initial begin : driver
        pipeline_cdb_t p;
        for (int s = 0; s < N; s++) begin
            sv[s] = 1'b0; wc[s] = 0; gen_pct[s] = 0; inj[s] = 1'b0; sp[s] = '0; inj_p[s] = '0;
        end
        repeat (2) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Lone FPU result on bank 1
        p = rand_payload(1); p.wid = 7'h07;
        inj[4] = 1'b1; inj_p[4] = p;
        step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        // ALU0 on bank 0 and LSU on bank 1 together
        p = rand_payload(0); p.wid = 7'h02; inj[0] = 1'b1; inj_p[0] = p;
        p = rand_payload(1); p.wid = 7'h05; inj[2] = 1'b1; inj_p[2] = p;
        step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        // Heavy bank-0 contention: ALU0, ALU1, FPU
        gen_bank = 0;
        gen_pct[0] = 100; gen_pct[1] = 100; gen_pct[4] = 100;
        repeat (30) step(1'b0, 1'b0);

        // Bank-1 contention: ALU1, MDU, FPU
        gen_bank = 1;
        gen_pct[0] = 0; gen_pct[1] = 100; gen_pct[3] = 100; gen_pct[4] = 100;
        repeat (30) step(1'b0, 1'b0);

        // Flush with several sources valid, then idle
        step(1'b1, 1'b0);
        for (int s = 0; s < N; s++) gen_pct[s] = 0;
        repeat (4) step(1'b0, 1'b0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 360; i++) begin
            if (i % 60 == 0) begin
                gen_bank = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(1));
                for (int s = 0; s < N; s++) gen_pct[s] = $urandom_range(90, 20);
            end
            step($urandom_range(24) == 0, $urandom_range(69) == 0);
        end

        for (int s = 0; s < N; s++) gen_pct[s] = 0;
        repeat (4) step(1'b0, 1'b0);
        @(posedge clk);
        #3;
        checks++;
        if (lane_q0.size() != 0 || lane_q1.size() != 0 || cyc_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got=%0d/%0d/%0d exp=0/0/0",
                     lane_q0.size(), lane_q1.size(), cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
